// File: rtl/memc3_reset_supervisor.sv
// Bring-up and recovery supervisor for the SDRAM memory path, clocked from the
// buffered board clock: sequences mem_rst_n, qualifies PLL lock and calibration, retries and faults.
module memc3_reset_supervisor #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned CALIB_TIMEOUT = 2000000,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       calib_done,
  input  logic       restart,
  output logic       mem_rst_n,
  output logic       app_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] err_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_STABLE     = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  localparam logic [23:0] HOLD_LAST   = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] CALIB_LAST  = 24'(CALIB_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  state_t      state;
  state_t      state_nxt;
  logic [23:0] cnt;
  logic        fail;
  logic        enter_run;

  logic lock_m, lock_s;
  logic calib_m, calib_s;

  // pll_lock and calib_done come from the memory clock domain; two flops each
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_m  <= 1'b0;
      lock_s  <= 1'b0;
      calib_m <= 1'b0;
      calib_s <= 1'b0;
    end else begin
      lock_m  <= pll_lock;
      lock_s  <= lock_m;
      calib_m <= calib_done;
      calib_s <= calib_m;
    end
  end

  always_comb begin
    state_nxt = state;
    fail      = 1'b0;
    enter_run = 1'b0;
    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                 state_nxt = ST_WAIT_CALIB;
        else if (cnt == LOCK_LAST)  fail = 1'b1;
      end
      ST_WAIT_CALIB: begin
        if (!lock_s)                fail = 1'b1;
        else if (calib_s)           state_nxt = ST_STABLE;
        else if (cnt == CALIB_LAST) fail = 1'b1;
      end
      ST_STABLE: begin
        if (!(lock_s && calib_s)) begin
          fail = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          enter_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s || !calib_s) fail = 1'b1;
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase

    if (fail) state_nxt = (retry_count == RETRY_MAX) ? ST_FAULT : ST_HOLD;

    // restart overrides everything, including a coincident failure
    if (restart) begin
      state_nxt = ST_HOLD;
      fail      = 1'b0;
      enter_run = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they move with the transition edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      mem_rst_n   <= 1'b0;
      app_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
      err_count   <= '0;
      state_dbg   <= 3'd0;
    end else begin
      state <= state_nxt;

      if ((state_nxt != state) || restart) cnt <= '0;
      else                                 cnt <= cnt + 24'd1;

      if (restart || enter_run)                 retry_count <= '0;
      else if (fail && (retry_count != RETRY_MAX)) retry_count <= retry_count + 4'd1;

      if (fail && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      mem_rst_n <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_WAIT_CALIB) ||
                   (state_nxt == ST_STABLE)    || (state_nxt == ST_RUN);
      app_rst   <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      fault     <= (state_nxt == ST_FAULT);
      state_dbg <= state_nxt;
    end
  end

endmodule

// File: tb/tb_memc3_reset_supervisor.sv
// Directed bench for memc3_reset_supervisor: bring-up, retries, fault, restart
// and asynchronous reset scenarios with hand-computed expectations.
module tb_memc3_reset_supervisor;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       calib_done = 1'b0;
  logic       restart = 1'b0;
  logic       mem_rst_n;
  logic       app_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] err_count;
  logic [2:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  memc3_reset_supervisor #(
    .HOLD_CYCLES  (4),
    .LOCK_TIMEOUT (20),
    .CALIB_TIMEOUT(30),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .calib_done (calib_done),
    .restart    (restart),
    .mem_rst_n  (mem_rst_n),
    .app_rst    (app_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .err_count  (err_count),
    .state_dbg  (state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one rising edge and land on the following falling edge
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Drive both qualifiers high and wait (bounded) for ready
  task automatic bring_up_to_run();
    pll_lock   = 1'b1;
    calib_done = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ready) break;
      tick();
    end
  endtask

  task automatic test_reset();
    #1 sys_rst_n = 1'b0;
    #3;
    tests_run++;
    if ({mem_rst_n, app_rst, ready, fault} !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL reset_levels: got mem_rst_n/app_rst/ready/fault=%b want 0100",
               {mem_rst_n, app_rst, ready, fault});
    end
    tests_run++;
    if ({retry_count, err_count, state_dbg} !== 15'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counts: got retry=%0d err=%0d state=%0d want 0/0/0",
               retry_count, err_count, state_dbg);
    end
  endtask

  task automatic test_normal_bringup();
    int low_cnt;
    sys_rst_n  = 1'b0;
    pll_lock   = 1'b0;
    calib_done = 1'b0;
    @(negedge sys_clk);
    tick();
    sys_rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rst_n) break;
      low_cnt++;
      tick();
    end
    tests_run++;
    if (low_cnt != 4) begin
      tests_failed++;
      $display("[TB] FAIL bringup_hold_width: got %0d low cycles want 4", low_cnt);
    end
    tests_run++;
    if (state_dbg !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL bringup_wait_lock: got state=%0d want 1", state_dbg);
    end
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (9) tick();
    calib_done = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (ready !== 1'b0 || state_dbg !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL bringup_early_ready: got ready=%b state=%0d want 0/3", ready, state_dbg);
    end
    tick();
    tests_run++;
    if ({ready, app_rst, mem_rst_n, state_dbg} !== 6'b101_100) begin
      tests_failed++;
      $display("[TB] FAIL bringup_run: got ready/app_rst/mem_rst_n=%b%b%b state=%0d want 101/4",
               ready, app_rst, mem_rst_n, state_dbg);
    end
    tests_run++;
    if (retry_count !== 4'd0 || err_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL bringup_counts: got retry=%0d err=%0d want 0/0", retry_count, err_count);
    end
  endtask

  task automatic test_lock_drop_in_run();
    int low_cnt;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lockdrop_latency_early: got ready=%b want 1", ready);
    end
    tick();
    tests_run++;
    if ({ready, app_rst, mem_rst_n} !== 3'b010 || err_count !== 8'd1 || retry_count !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL lockdrop_fail: got ready/app_rst/mem_rst_n=%b%b%b err=%0d retry=%0d want 010/1/1",
               ready, app_rst, mem_rst_n, err_count, retry_count);
    end
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rst_n) break;
      low_cnt++;
      tick();
    end
    tests_run++;
    if (low_cnt != 4) begin
      tests_failed++;
      $display("[TB] FAIL lockdrop_hold_width: got %0d low cycles want 4", low_cnt);
    end
    bring_up_to_run();
    tests_run++;
    if (ready !== 1'b1 || retry_count !== 4'd0 || err_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL lockdrop_relock: got ready=%b retry=%0d err=%0d want 1/0/1",
               ready, retry_count, err_count);
    end
  endtask

  task automatic test_calib_glitch_in_stable();
    logic saw_ready;
    sys_rst_n  = 1'b0;
    pll_lock   = 1'b1;
    calib_done = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (state_dbg == 3'd2) break;
      tick();
    end
    calib_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state_dbg == 3'd3) break;
    end
    repeat (4) tick();
    calib_done = 1'b0;
    tick();
    calib_done = 1'b1;
    saw_ready = ready;
    tick();
    saw_ready |= ready;
    tick();
    saw_ready |= ready;
    tests_run++;
    if (state_dbg !== 3'd0 || mem_rst_n !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_to_hold: got state=%0d mem_rst_n=%b want 0/0", state_dbg, mem_rst_n);
    end
    tests_run++;
    if (saw_ready !== 1'b0 || err_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL glitch_no_ready: got saw_ready=%b err=%0d want 0/1", saw_ready, err_count);
    end
  endtask

  task automatic test_lock_never();
    int run_len;
    sys_rst_n  = 1'b0;
    pll_lock   = 1'b0;
    calib_done = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_len = 0;
      for (int i = 0; i < 60; i++) begin
        if (mem_rst_n) break;
        run_len++;
        tick();
      end
      tests_run++;
      if (run_len != 4) begin
        tests_failed++;
        $display("[TB] FAIL nolock_low_%0d: got %0d cycles want 4", p, run_len);
      end
      run_len = 0;
      for (int i = 0; i < 60; i++) begin
        if (!mem_rst_n) break;
        run_len++;
        tick();
      end
      tests_run++;
      if (run_len != 20) begin
        tests_failed++;
        $display("[TB] FAIL nolock_high_%0d: got %0d cycles want 20", p, run_len);
      end
    end
    tests_run++;
    if ({fault, mem_rst_n, app_rst} !== 3'b101 || err_count !== 8'd3 ||
        retry_count !== 4'd2 || state_dbg !== 3'd5) begin
      tests_failed++;
      $display("[TB] FAIL nolock_fault: got fault/mem_rst_n/app_rst=%b%b%b err=%0d retry=%0d state=%0d want 101/3/2/5",
               fault, mem_rst_n, app_rst, err_count, retry_count, state_dbg);
    end
    pll_lock = 1'b1;
    repeat (6) tick();
    tests_run++;
    if (fault !== 1'b1 || state_dbg !== 3'd5 || mem_rst_n !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL nolock_sticky: got fault=%b state=%0d mem_rst_n=%b want 1/5/0",
               fault, state_dbg, mem_rst_n);
    end
  endtask

  task automatic test_restart_from_fault();
    int low_cnt;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests_run++;
    if (state_dbg !== 3'd0 || fault !== 1'b0 || retry_count !== 4'd0 || err_count !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL restart_fault: got state=%0d fault=%b retry=%0d err=%0d want 0/0/0/3",
               state_dbg, fault, retry_count, err_count);
    end
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rst_n) break;
      low_cnt++;
      tick();
    end
    tests_run++;
    if (low_cnt != 4) begin
      tests_failed++;
      $display("[TB] FAIL restart_hold_width: got %0d low cycles want 4", low_cnt);
    end
  endtask

  task automatic test_restart_with_lock_drop();
    bring_up_to_run();
    tests_run++;
    if (ready !== 1'b1 || err_count !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL restart_pre_run: got ready=%b err=%0d want 1/3", ready, err_count);
    end
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests_run++;
    if (state_dbg !== 3'd0 || err_count !== 8'd3 || retry_count !== 4'd0 || ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_coincide: got state=%0d err=%0d retry=%0d ready=%b want 0/3/0/0",
               state_dbg, err_count, retry_count, ready);
    end
  endtask

  task automatic test_async_reset_mid_run();
    bring_up_to_run();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_pre_run: got ready=%b want 1", ready);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_rst_n, app_rst, ready, fault} !== 4'b0100 ||
        {retry_count, err_count, state_dbg} !== 15'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got levels=%b retry=%0d err=%0d state=%0d want 0100/0/0/0",
               {mem_rst_n, app_rst, ready, fault}, retry_count, err_count, state_dbg);
    end
    test_normal_bringup();
  endtask

  initial begin
    test_reset();
    test_normal_bringup();
    test_lock_drop_in_run();
    test_calib_glitch_in_stable();
    test_lock_never();
    test_restart_from_fault();
    test_restart_with_lock_drop();
    test_async_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
